// File: rtl/blackbox_add_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ
// requesters; results are captured with the requester id into a one-entry response register.
module blackbox_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       io_req_valid,
    output logic [NUM_REQ-1:0]       io_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] io_req_bits,
    output logic [WIDTH-1:0]         io_add_in,
    input  logic [WIDTH-1:0]         io_add_out,
    output logic                     io_resp_valid,
    input  logic                     io_resp_ready,
    output logic [WIDTH-1:0]         io_resp_bits,
    output logic [ID_W-1:0]          io_resp_id
);

    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_bits_q,  resp_bits_d;
    logic [ID_W-1:0]  resp_id_q,    resp_id_d;

    logic [ID_W-1:0]  grant_idx;
    logic             found;
    logic             any_valid;
    logic             slot_free;
    logic             accept;

    assign any_valid = |io_req_valid;
    assign slot_free = !resp_valid_q || io_resp_ready;
    assign accept    = any_valid && slot_free;

    // Rotating search as two passes: indices above last_grant first, then wrap to the rest.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && io_req_valid[i] && (ID_W'(i) > last_grant_q)) begin
                grant_idx = ID_W'(i);
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && io_req_valid[i] && (ID_W'(i) <= last_grant_q)) begin
                grant_idx = ID_W'(i);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        io_add_in    = '0;
        io_req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (any_valid && (ID_W'(i) == grant_idx)) begin
                io_add_in = io_req_bits[i*WIDTH +: WIDTH];
            end
            // Reset gating keeps ready low while the block is held in reset.
            io_req_ready[i] = accept && reset && (ID_W'(i) == grant_idx);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_bits_d  = resp_bits_q;
        resp_id_d    = resp_id_q;
        if (accept) begin
            resp_bits_d  = io_add_out;
            resp_id_d    = grant_idx;
            resp_valid_d = 1'b1;
            last_grant_d = grant_idx;
        end else if (resp_valid_q && io_resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
            resp_id_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_bits_q  <= resp_bits_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_bits  = resp_bits_q;
    assign io_resp_id    = resp_id_q;

endmodule

// File: tb/tb_blackbox_add_arbiter.sv
// Bench for blackbox_add_arbiter: directed scenarios plus randomized traffic
// checked against a rotating-priority reference model with an in+1 adder.
module tb_blackbox_add_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [63:0] bits;
    logic [15:0] add_in;
    logic [15:0] add_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_bits;
    logic [1:0]  resp_id;

    int total = 0;
    int bad   = 0;

    logic [15:0] op [4];

    // Reference model state
    int          m_last;
    logic        m_rv;
    logic [15:0] m_rb;
    int          m_rid;

    blackbox_add_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .io_req_valid (valid),
        .io_req_ready (ready),
        .io_req_bits  (bits),
        .io_add_in    (add_in),
        .io_add_out   (add_out),
        .io_resp_valid(resp_valid),
        .io_resp_ready(resp_ready),
        .io_resp_bits (resp_bits),
        .io_resp_id   (resp_id)
    );

    assign add_out = add_in + 16'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        bits = {op[3], op[2], op[1], op[0]};
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Priority distance from the last grant: smallest distance wins.
    function automatic int ref_grant(input logic [3:0] v, input int last);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = 99;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + 8) % 4;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic test_reset();
        valid = 4'hF; resp_ready = 1'b1;
        op[0] = 16'h1; op[1] = 16'h2; op[2] = 16'h3; op[3] = 16'h4; load_ops();
        rst_n = 1'b0;
        #7;
        total++; if (ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        valid = 4'h0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL idle_resp_valid cyc=%0d got=%b exp=0", k, resp_valid); end
            total++; if (ready !== 4'b0000) begin bad++; $display("FAIL idle_ready cyc=%0d got=%b exp=0000", k, ready); end
            total++; if (add_in !== 16'h0000) begin bad++; $display("FAIL idle_add_in cyc=%0d got=%h exp=0000", k, add_in); end
            total++; if (resp_bits !== 16'h0000 || resp_id !== 2'd0) begin bad++; $display("FAIL idle_resp_regs cyc=%0d got=%h/%0d exp=0000/0", k, resp_bits, resp_id); end
        end
        tick();
    endtask

    task automatic test_single();
        op[2] = 16'h0010; load_ops();
        valid = 4'b0100; resp_ready = 1'b1;
        @(negedge clk);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", ready); end
        total++; if (add_in !== 16'h0010) begin bad++; $display("FAIL single_add_in got=%h exp=0010", add_in); end
        tick();
        valid = 4'b0000;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_resp_valid got=%b exp=1", resp_valid); end
        total++; if (resp_bits !== 16'h0011) begin bad++; $display("FAIL single_resp_bits got=%h exp=0011", resp_bits); end
        total++; if (resp_id !== 2'd2) begin bad++; $display("FAIL single_resp_id got=%0d exp=2", resp_id); end
        tick();
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", resp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < 4; i++) op[i] = 16'h0100 + 16'(i);
        load_ops();
        valid = 4'hF; resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, ready, 4'(1 << (k % 4))); end
            total++; if (add_in !== 16'h0100 + 16'(k % 4)) begin bad++; $display("FAIL rr_add_in cyc=%0d got=%h exp=%h", k, add_in, 16'h0100 + 16'(k % 4)); end
            if (k > 0) begin
                total++;
                if (resp_valid !== 1'b1 || resp_bits !== 16'h0101 + 16'((k - 1) % 4) || resp_id !== 2'((k - 1) % 4)) begin
                    bad++;
                    $display("FAIL rr_resp cyc=%0d got=%b/%h/%0d exp=1/%h/%0d", k, resp_valid, resp_bits, resp_id,
                             16'h0101 + 16'((k - 1) % 4), (k - 1) % 4);
                end
            end
            tick();
        end
        valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        pulse_reset();
        op[0] = 16'h0000; op[3] = 16'h0033; load_ops();
        valid = 4'b1001; resp_ready = 1'b0;
        @(negedge clk);
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL bp_first_ready got=%b exp=0001", ready); end
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (ready !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, ready); end
            total++;
            if (resp_valid !== 1'b1 || resp_bits !== 16'h0001 || resp_id !== 2'd0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1/0001/0", k, resp_valid, resp_bits, resp_id);
            end
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++; if (ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", ready); end
        tick();
        valid = 4'h0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_bits !== 16'h0034 || resp_id !== 2'd3) begin
            bad++; $display("FAIL bp_after got=%b/%h/%0d exp=1/0034/3", resp_valid, resp_bits, resp_id);
        end
        tick();
    endtask

    task automatic test_wrap();
        op[1] = 16'hFFFF; load_ops();
        valid = 4'b0010; resp_ready = 1'b1;
        @(negedge clk);
        total++; if (ready !== 4'b0010) begin bad++; $display("FAIL wrap_ready got=%b exp=0010", ready); end
        tick();
        valid = 4'h0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_bits !== 16'h0000 || resp_id !== 2'd1) begin
            bad++; $display("FAIL wrap_resp got=%b/%h/%0d exp=1/0000/1", resp_valid, resp_bits, resp_id);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        op[1] = 16'h0200; op[2] = 16'h0300; load_ops();
        valid = 4'b0110; resp_ready = 1'b0;
        tick();
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", resp_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", resp_valid); end
        total++; if (ready !== 4'b0000) begin bad++; $display("FAIL mid_async_ready got=%b exp=0000", ready); end
        #2;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        total++; if (ready !== 4'b0010) begin bad++; $display("FAIL mid_first_grant got=%b exp=0010", ready); end
        total++; if (add_in !== 16'h0200) begin bad++; $display("FAIL mid_add_in got=%h exp=0200", add_in); end
        valid = 4'h0;
        tick();
    endtask

    task automatic test_random();
        int          g;
        logic [3:0]  exp_ready;
        logic [15:0] exp_add;
        logic        acc;
        valid = 4'h0;
        pulse_reset();
        m_last = 3; m_rv = 1'b0; m_rb = 16'h0; m_rid = 0;
        for (int k = 0; k < 400; k++) begin
            valid = 4'($urandom);
            for (int i = 0; i < 4; i++) op[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) op[$urandom_range(0, 3)] = 16'hFFFF;
            load_ops();
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g         = ref_grant(valid, m_last);
            acc       = (g >= 0) && (!m_rv || resp_ready);
            exp_ready = acc ? 4'(1 << g) : 4'b0000;
            exp_add   = (g >= 0) ? op[g] : 16'h0000;
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, ready, exp_ready); end
            total++; if (add_in !== exp_add) begin bad++; $display("FAIL rnd_add_in cyc=%0d got=%h exp=%h", k, add_in, exp_add); end
            total++;
            if (resp_valid !== m_rv || resp_bits !== m_rb || resp_id !== 2'(m_rid)) begin
                bad++;
                $display("FAIL rnd_resp cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", k, resp_valid, resp_bits, resp_id, m_rv, m_rb, m_rid);
            end
            @(posedge clk);
            if (acc) begin
                m_rb   = op[g] + 16'd1;
                m_rid  = g;
                m_rv   = 1'b1;
                m_last = g;
            end else if (m_rv && resp_ready) begin
                m_rv = 1'b0;
            end
            #1;
        end
        valid = 4'h0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; valid = 4'h0; bits = '0; resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) op[i] = 16'h0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
